serial_frame_tx: RTL and testbench

- Serial frame transmitter: the sending end of the start-bit / length-field / payload serial protocol that our sequence-receiving controller decodes.
- Accepts a parallel payload and length through a ready/start handshake.
- Serialises it on a single line: one start bit, then a LEN_W-bit length field (MSB first), then `len` payload bits (LSB first).
- Sits between the parallel producer and the serial link feeding the receiver.

---
 rtl/serial_frame_pkg.sv | 23 ++
 rtl/serial_frame_tx_datapath.sv | 88 ++++++++
 rtl/serial_frame_tx.sv | 117 +++++++++++
 tb/tb_serial_frame_tx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame link (transmitter and receiver).
// Holds the controller state encoding, the default field widths and a helper
// for sizing the bit counter.
package serial_frame_pkg;

  localparam int LEN_W_DEF  = 4;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    LEN     = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

  // The counter only has to reach max(len_w, data_w) - 1; keep at least 1 bit.
  function automatic int cnt_width(input int len_w, input int data_w);
    int m;
    m = (len_w > data_w) ? len_w : data_w;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/serial_frame_tx_datapath.sv
// Datapath of the serial frame transmitter: effective-length register, payload
// shift register, bit down-counter with zero flag and the registered sout mux.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cap_i               capture clamped length and payload (frame accepted)
//   ld_len_i            load counter for the length field (LEN_W-1)
//   ld_pay_i            load counter for the payload (n-1)
//   dec_i               decrement counter
//   shift_i             shift payload right, zero-filled
//   sel_i               state of the next cycle; selects the next sout source
//   len_i, data_i       raw length and payload from the producer
//   cnt_zero_o          counter is zero (current phase ends this cycle)
//   n_zero_o            captured effective length is zero
//   sout_o              registered serial line
module serial_frame_tx_datapath
  import serial_frame_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cap_i,
  input  logic              ld_len_i,
  input  logic              ld_pay_i,
  input  logic              dec_i,
  input  logic              shift_i,
  input  state_e            sel_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              cnt_zero_o,
  output logic              n_zero_o,
  output logic              sout_o
);

  localparam int CNT_W = cnt_width(LEN_W, DATA_W);

  logic [LEN_W-1:0]  n_in, n_q, n_d, n_m1, n_shr;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sout_q, sout_d;

  always_comb begin
    // Clamp to the payload register size; the line carries the clamped value.
    n_in = (int'(len_i) > DATA_W) ? LEN_W'(DATA_W) : len_i;
    n_d  = cap_i ? n_in : n_q;
    n_m1 = n_q - LEN_W'(1);

    shift_d = shift_q;
    if (cap_i)        shift_d = data_i;
    else if (shift_i) shift_d = shift_q >> 1;

    cnt_d = cnt_q;
    if (ld_len_i)      cnt_d = CNT_W'(LEN_W - 1);
    else if (ld_pay_i) cnt_d = CNT_W'(n_m1);
    else if (dec_i)    cnt_d = cnt_q - CNT_W'(1);

    // sout is registered, so it is computed from next-cycle values.
    n_shr  = n_d >> cnt_d;
    sout_d = 1'b0;
    case (sel_i)
      IDLE:    sout_d = 1'b0;
      START:   sout_d = 1'b1;
      LEN:     sout_d = n_shr[0];
      PAYLOAD: sout_d = shift_d[0];
      default: sout_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q     <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
    end else begin
      n_q     <= n_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
    end
  end

  assign cnt_zero_o = (cnt_q == '0);
  assign n_zero_o   = (n_q == '0);
  assign sout_o     = sout_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LEN_W-bit length (MSB first), then n
// payload bits (LSB first), with n = min(len, DATA_W). Controller lives here,
// datapath in serial_frame_tx_datapath.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        frame request, accepted when ready_o=1
//   len_i, data_i  payload length and payload, sampled on acceptance
//   ready_o        idle, start will be accepted
//   busy_o         frame in progress
//   sout_o         serial line, idles at 0
//   done_o         one-cycle pulse in the first idle cycle after a frame
//
// state   | meaning
// IDLE    | line 0, ready; start captures n and data
// START   | line 1 for one cycle
// LEN     | length field, LEN_W bits MSB first
// PAYLOAD | n payload bits LSB first
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              sout_o,
  output logic              done_o
);

  state_e state_q, state_d;
  logic   ready_q, busy_q, done_q;
  logic   cap, ld_len, ld_pay, dec, shift;
  logic   cnt_zero, n_zero;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    ld_len  = 1'b0;
    ld_pay  = 1'b0;
    dec     = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = START;
          cap     = 1'b1;
        end
      end
      START: begin
        state_d = LEN;
        ld_len  = 1'b1;
      end
      LEN: begin
        if (!cnt_zero) begin
          dec = 1'b1;
        end else if (n_zero) begin
          state_d = IDLE;
        end else begin
          state_d = PAYLOAD;
          ld_pay  = 1'b1;
        end
      end
      PAYLOAD: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          dec   = 1'b1;
          shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
    end
  end

  serial_frame_tx_datapath #(
    .LEN_W  (LEN_W),
    .DATA_W (DATA_W)
  ) u_dp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cap_i      (cap),
    .ld_len_i   (ld_len),
    .ld_pay_i   (ld_pay),
    .dec_i      (dec),
    .shift_i    (shift),
    .sel_i      (state_d),
    .len_i      (len_i),
    .data_i     (data_i),
    .cnt_zero_o (cnt_zero),
    .n_zero_o   (n_zero),
    .sout_o     (sout_o)
  );

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed scenarios plus random frames, each
// cycle compared against a bit list built from the frame format.
module tb_serial_frame_tx;

  localparam int LEN_W  = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] data;
  logic              ready, busy, sout, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(
    .LEN_W  (LEN_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .len_i   (len),
    .data_i  (data),
    .ready_o (ready),
    .busy_o  (busy),
    .sout_o  (sout),
    .done_o  (done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, " sout"},  sout,  1'b0);
    chk({tag, " ready"}, ready, 1'b1);
    chk({tag, " busy"},  busy,  1'b0);
    chk({tag, " done"},  done,  exp_done);
  endtask

  // Called right after a negedge; each cycle checked at its negedge.
  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk_idle(tag, 1'b0);
    end
  endtask

  // Called right after a negedge of a cycle in which ready=1. Returns right
  // after the negedge of the done cycle (or of the post-reset cycle).
  task automatic frame(input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] d,
                       input int pulse_at, input int rst_at, input string name);
    bit exp_q[$];
    int n;
    bit aborted;
    aborted = 1'b0;
    n = (int'(l) > DATA_W) ? DATA_W : int'(l);
    exp_q.push_back(1'b1);
    for (int i = LEN_W - 1; i >= 0; i--) exp_q.push_back(bit'((n >> i) & 1));
    for (int i = 0; i < n; i++) exp_q.push_back(d[i]);

    len   = l;
    data  = d;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d sout", name, c),  sout,  exp_q[c-1]);
      chk($sformatf("%s c%0d busy", name, c),  busy,  1'b1);
      chk($sformatf("%s c%0d ready", name, c), ready, 1'b0);
      chk($sformatf("%s c%0d done", name, c),  done,  1'b0);
      start = (c == pulse_at);
      len   = LEN_W'($urandom);
      data  = DATA_W'($urandom);
      if (c == rst_at) begin
        rst     = 1'b1;
        aborted = 1'b1;
        @(posedge clk);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    if (aborted) begin
      rst = 1'b0;
      chk_idle({name, " after rst"}, 1'b0);
    end else begin
      chk_idle({name, " done"}, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [LEN_W-1:0]  rl;
    logic [DATA_W-1:0] rd;

    rst   = 1'b1;
    start = 1'b1;
    len   = 4'd3;
    data  = 16'h0005;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk_idle("reset", 1'b0);
    end
    rst   = 1'b0;
    start = 1'b0;
    idle(2, "post reset");

    frame(4'd3, 16'h0005, 0, 0, "len3");
    idle(1, "len3 after");

    frame(4'd0, 16'hFFFF, 0, 0, "len0");
    idle(1, "len0 after");

    frame(4'd15, 16'hFFFF, 10, 0, "len15");
    idle(1, "len15 after");

    frame(4'd1, 16'h0001, 0, 0, "b2b_a");
    frame(4'd2, 16'h0002, 0, 0, "b2b_b");
    idle(1, "b2b after");

    frame(4'd8, 16'h5A3C, 0, 7, "abort");
    idle(3, "abort idle");
    frame(4'd8, 16'hA5C3, 0, 0, "after_abort");
    idle(1, "after_abort idle");

    repeat (30) begin
      rl = LEN_W'($urandom_range(0, 15));
      rd = DATA_W'($urandom);
      frame(rl, rd, int'($urandom_range(0, 20)), 0, "rnd");
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), "rnd gap");
    end
    idle(1, "end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
